me_search: RTL and testbench

- Parametrised full-search integer motion estimator for the inter-prediction path.
- Buffers one current macroblock (CPR). Sweeps every candidate position inside a search window (SPR) read from an external row memory.
- Returns the minimum SAD and its motion vector, with optional threshold-based early termination.
- Sits between the search-window/current-MB memories and the mode-decision stage.

---
 rtl/me_search_if.sv | 42 ++++
 rtl/me_search.sv | 180 ++++++++++++++++++
 tb/tb_me_search.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_search_if.sv
// me_search request/result bundle: start + threshold, CPR row load,
// SPR row-memory read port, busy/valid and the best SAD / motion vector.
interface me_search_if #(
  parameter int PIXEL_W    = 8,
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
);
  localparam int N_POS = SEARCH_DIM - MACRO_DIM + 1;
  localparam int MV_W  = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int SAD_W =
    $clog2(MACRO_DIM * MACRO_DIM * (2**PIXEL_W - 1) + 1);
  localparam int ROW_W = (SEARCH_DIM > 1) ? $clog2(SEARCH_DIM) : 1;

  logic                               start;
  logic                               thr_en;
  logic [SAD_W-1:0]                   sad_thr;
  logic                               cpr_valid;
  logic [MACRO_DIM-1:0][PIXEL_W-1:0]  pixel_cpr_in;
  logic                               spr_rd_en;
  logic [ROW_W-1:0]                   spr_row;
  logic [MV_W-1:0]                    spr_col;
  logic [MACRO_DIM-1:0][PIXEL_W-1:0]  pixel_spr_in;
  logic                               busy;
  logic                               valid;
  logic [SAD_W-1:0]                   min_sad;
  logic [MV_W-1:0]                    mv_x;
  logic [MV_W-1:0]                    mv_y;

  modport master (
    output start, thr_en, sad_thr, cpr_valid, pixel_cpr_in,
    output pixel_spr_in,
    input  spr_rd_en, spr_row, spr_col,
    input  busy, valid, min_sad, mv_x, mv_y
  );

  modport slave (
    input  start, thr_en, sad_thr, cpr_valid, pixel_cpr_in,
    input  pixel_spr_in,
    output spr_rd_en, spr_row, spr_col,
    output busy, valid, min_sad, mv_x, mv_y
  );
endinterface

// File: rtl/me_search.sv
// Full-search integer motion estimator: loads one current MB, sweeps all
// window positions in raster order and reports min SAD + motion vector.
module me_search #(
  parameter int PIXEL_W    = 8,
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input logic       clk,
  input logic       rst_n,
  me_search_if.slave bus
);
  localparam int N_POS = SEARCH_DIM - MACRO_DIM + 1;
  localparam int MV_W  = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int SAD_W =
    $clog2(MACRO_DIM * MACRO_DIM * (2**PIXEL_W - 1) + 1);
  localparam int ROW_W = (SEARCH_DIM > 1) ? $clog2(SEARCH_DIM) : 1;
  localparam int RW    = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1;
  localparam logic [RW-1:0]   R_LAST = RW'(MACRO_DIM - 1);
  localparam logic [MV_W-1:0] P_LAST = MV_W'(N_POS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;
  typedef logic [MACRO_DIM-1:0][PIXEL_W-1:0] row_t;

  state_t           state;
  row_t             cpr [MACRO_DIM];
  logic [RW-1:0]    ld_cnt;
  logic [RW-1:0]    iss_r;
  logic [RW-1:0]    rd_r;
  logic [RW-1:0]    nr;
  logic [MV_W-1:0]  iss_x;
  logic [MV_W-1:0]  iss_y;
  logic [MV_W-1:0]  nx;
  logic [MV_W-1:0]  ny;
  logic [MV_W-1:0]  cmp_x;
  logic [MV_W-1:0]  cmp_y;
  logic             rd_v;
  logic             cand_v;
  logic             thr_en_q;
  logic [SAD_W-1:0] thr_q;
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] acc_nxt;
  logic [SAD_W-1:0] cand_sad;
  logic [SAD_W-1:0] row_sad;
  logic             last_row;
  logic             last_col;
  logic             last_pos;
  logic             cmp_last;
  logic             better;
  logic             hit;

  always_comb begin
    row_sad = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      if (cpr[rd_r][i] > bus.pixel_spr_in[i])
        row_sad = row_sad +
          SAD_W'(cpr[rd_r][i] - bus.pixel_spr_in[i]);
      else
        row_sad = row_sad +
          SAD_W'(bus.pixel_spr_in[i] - cpr[rd_r][i]);
    end
  end

  // Read-issue walker: (x, y, r) of the read on the bus this cycle.
  always_comb begin
    last_row = (iss_r == R_LAST);
    last_col = (iss_x == P_LAST);
    last_pos = last_row && last_col && (iss_y == P_LAST);
    nr = last_row ? '0 : iss_r + 1'b1;
    nx = last_row ? (last_col ? '0 : iss_x + 1'b1) : iss_x;
    ny = (last_row && last_col) ? iss_y + 1'b1 : iss_y;
  end

  always_comb begin
    acc_nxt  = (rd_r == '0) ? row_sad : acc + row_sad;
    cmp_last = (cmp_x == P_LAST) && (cmp_y == P_LAST);
    better   = ((cmp_x == '0) && (cmp_y == '0)) ||
               (cand_sad < bus.min_sad);
    hit      = thr_en_q && (cand_sad <= thr_q);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.cpr_valid)
      cpr[ld_cnt] <= bus.pixel_cpr_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld_cnt        <= '0;
      iss_r         <= '0;
      iss_x         <= '0;
      iss_y         <= '0;
      rd_r          <= '0;
      rd_v          <= 1'b0;
      cand_v        <= 1'b0;
      cmp_x         <= '0;
      cmp_y         <= '0;
      thr_en_q      <= 1'b0;
      thr_q         <= '0;
      acc           <= '0;
      cand_sad      <= '0;
      bus.spr_rd_en <= 1'b0;
      bus.spr_row   <= '0;
      bus.spr_col   <= '0;
      bus.busy      <= 1'b0;
      bus.valid     <= 1'b0;
      bus.min_sad   <= '0;
      bus.mv_x      <= '0;
      bus.mv_y      <= '0;
    end else begin
      bus.valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            thr_en_q <= bus.thr_en;
            thr_q    <= bus.sad_thr;
            ld_cnt   <= '0;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (bus.cpr_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == R_LAST) begin
              state         <= SEARCH;
              bus.spr_rd_en <= 1'b1;
              bus.spr_row   <= '0;
              bus.spr_col   <= '0;
              iss_r         <= '0;
              iss_x         <= '0;
              iss_y         <= '0;
              cmp_x         <= '0;
              cmp_y         <= '0;
              rd_v          <= 1'b0;
              cand_v        <= 1'b0;
            end
          end
        end
        SEARCH: begin
          rd_v   <= bus.spr_rd_en;
          rd_r   <= iss_r;
          cand_v <= rd_v && (rd_r == R_LAST);
          if (rd_v) begin
            acc <= acc_nxt;
            if (rd_r == R_LAST)
              cand_sad <= acc_nxt;
          end
          if (bus.spr_rd_en) begin
            iss_r         <= nr;
            iss_x         <= nx;
            iss_y         <= ny;
            bus.spr_row   <= ROW_W'(ny) + ROW_W'(nr);
            bus.spr_col   <= nx;
            bus.spr_rd_en <= !last_pos;
          end
          if (cand_v) begin
            // A threshold hit always wins: every earlier SAD was > thr.
            if (better || hit) begin
              bus.min_sad <= cand_sad;
              bus.mv_x    <= cmp_x;
              bus.mv_y    <= cmp_y;
            end
            cmp_x <= (cmp_x == P_LAST) ? '0 : cmp_x + 1'b1;
            cmp_y <= (cmp_x == P_LAST) ? cmp_y + 1'b1 : cmp_y;
            // In-flight reads for the next candidate are dropped.
            if (cmp_last || hit) begin
              state         <= DONE;
              bus.valid     <= 1'b1;
              bus.busy      <= 1'b0;
              bus.spr_rd_en <= 1'b0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_search.sv
// Bench for me_search at MACRO_DIM=4, SEARCH_DIM=8: row-memory model,
// brute-force reference, scoreboard of expected results popped on valid.
module tb_me_search;
  localparam int PW    = 8;
  localparam int M     = 4;
  localparam int S     = 8;
  localparam int N     = S - M + 1;
  localparam int SAD_W = $clog2(M * M * (2**PW - 1) + 1);

  typedef struct {
    int sad;
    int x;
    int y;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_search_if #(.PIXEL_W(PW), .MACRO_DIM(M), .SEARCH_DIM(S)) bus();

  me_search #(.PIXEL_W(PW), .MACRO_DIM(M), .SEARCH_DIM(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [PW-1:0] cpr [M][M];
  logic [PW-1:0] win [S][S];
  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int nvalid = 0;
  int cyc = 0;
  bit in_s = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.spr_rd_en)
      for (int i = 0; i < M; i++)
        bus.pixel_spr_in[i] <= win[bus.spr_row][int'(bus.spr_col) + i];
    else
      bus.pixel_spr_in <= '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_s = 1'b0;
    end else begin
      if (in_s) cyc++;
      else if (bus.spr_rd_en) begin
        in_s = 1'b1;
        cyc = 0;
      end
      if (in_s && cyc == 1) check("busy_run", int'(bus.busy), 1);
      if (bus.valid) begin
        nvalid++;
        in_s = 1'b0;
        if (sb.size() == 0) check("spurious_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("min_sad", int'(bus.min_sad), e.sad);
          check("mv_x", int'(bus.mv_x), e.x);
          check("mv_y", int'(bus.mv_y), e.y);
          check("latency", cyc, e.lat);
          check("rd_off", int'(bus.spr_rd_en), 0);
          check("busy_done", int'(bus.busy), 0);
        end
      end
    end
  end

  task automatic ref_search(input bit te, input int thr,
                            output int bs, output int bx,
                            output int by, output int kl);
    bit found = 1'b0;
    bs = 0; bx = 0; by = 0; kl = N * N - 1;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) begin
        int s = 0;
        int d;
        if (!found) begin
          for (int r = 0; r < M; r++)
            for (int i = 0; i < M; i++) begin
              d = int'(cpr[r][i]) - int'(win[y + r][x + i]);
              s += (d < 0) ? -d : d;
            end
          if ((y == 0 && x == 0) || s < bs) begin
            bs = s; bx = x; by = y;
          end
          if (te && s <= thr) begin
            bs = s; bx = x; by = y;
            kl = y * N + x;
            found = 1'b1;
          end
        end
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) win[r][c] = PW'($urandom_range(0, 255));
  endtask

  task automatic cpr_rand();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) cpr[r][c] = PW'($urandom_range(0, 255));
  endtask

  task automatic copy_cpr(input int x, input int y);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) cpr[r][c] = win[y + r][x + c];
  endtask

  task automatic place(input int x, input int y);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) win[y + r][x + c] = cpr[r][c];
  endtask

  task automatic start_search(input bit te, input int thr,
                              input logic [15:0] pat, input int npat);
    exp_t e;
    int kl;
    int row = 0;
    int idx = 0;
    bit v;
    ref_search(te, thr, e.sad, e.x, e.y, kl);
    e.lat = (kl + 1) * M + 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.thr_en = te;
    bus.sad_thr = SAD_W'(thr);
    bus.cpr_valid = 1'b1;
    for (int i = 0; i < M; i++) bus.pixel_cpr_in[i] = 8'hab;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    while (row < M) begin
      v = (idx < npat) ? pat[idx] : 1'b1;
      idx++;
      bus.cpr_valid = v;
      for (int i = 0; i < M; i++)
        bus.pixel_cpr_in[i] = v ? cpr[row][i] : 8'h5a;
      @(negedge clk);
      if (v) row++;
    end
    bus.cpr_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input bit poke);
    int v0 = nvalid;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      bus.start = poke && (i == 20 || bus.valid);
      if (bus.valid) seen = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (!seen) check("timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("busy_after", int'(bus.busy), 0);
    check("one_valid", nvalid - v0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, int'(bus.spr_rd_en), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_sad"}, int'(bus.min_sad), 0);
    check({tag, "_mvx"}, int'(bus.mv_x), 0);
    check({tag, "_mvy"}, int'(bus.mv_y), 0);
  endtask

  initial begin
    bit reached = 1'b0;
    bus.start = 1'b0;
    bus.thr_en = 1'b0;
    bus.sad_thr = '0;
    bus.cpr_valid = 1'b0;
    bus.pixel_cpr_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) win[r][c] = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) cpr[r][c] = '0;
    start_search(1'b0, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    fill_rand();
    copy_cpr(3, 2);
    start_search(1'b0, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    start_search(1'b0, 0, 16'b1011001, 7);
    wait_valid(300, 1'b1);

    cpr_rand();
    cpr[3][3] = cpr[0][0];
    fill_rand();
    place(1, 1);
    place(4, 4);
    start_search(1'b0, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) win[r][c] = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) cpr[r][c] = 8'hff;
    start_search(1'b0, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    cpr_rand();
    fill_rand();
    place(2, 0);
    start_search(1'b1, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    fill_rand();
    copy_cpr(1, 3);
    start_search(1'b0, 0, 16'h0, 0);
    for (int i = 0; i < 300 && !reached; i++) begin
      @(posedge clk);
      if (in_s && cyc >= 50) reached = 1'b1;
    end
    if (!reached) check("reach_cyc50", 0, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fill_rand();
    copy_cpr(0, 4);
    start_search(1'b0, 0, 16'h0, 0);
    wait_valid(300, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
